data_cal_seq: RTL and testbench
===============================

# data_cal_seq

Parametrised lane-sum unit, successor to the fixed 16-bit nibble calculator in the practice datapath. It captures a word of `LANES` fields of `LANE_W` bits each, then adds field 0 to a selected field, either on single requests or as an automatic sweep over all fields. Results come out on a registered interface with valid, last and busy flags. The block feeds the downstream result checkers in the same exercise chain.

## Interface
- `LANES`, default 4: number of fields in `d`; legal range 2–16.
- `LANE_W`, default 4: width of each field in bits; legal range 1–16.
- `SEL_W`, derived, equal to $clog2(LANES): width of `sel`. It is a localparam, not an override.
- `clk`  in  1  single clock; everything changes on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `d`  in  `LANES*LANE_W`  data word; field k is `d[k*LANE_W +: LANE_W]`.
- `load`  in  1  capture `d` into the internal register.
- `req`  in  1  single-sum request, using `sel`.
- `sel`  in  `SEL_W`  field index for `req`.
- `start`  in  1  launch a sweep over fields 1 to `LANES-1`.
- `out`  out  `LANE_W+1`  registered sum.
- `validout`  out  1  `out` is valid this cycle.
- `last`  out  1  final result of a sweep.
- `busy`  out  1  a sweep is in progress; commands are ignored.

## Operation
- Reset values:
  - `d_reg` = 0.
  - `out` = 0, `validout` = 0, `last` = 0, `busy` = 0.
  - State = IDLE, sweep index = 1.
- Sum rule: `out` = zero-extended field0 + zero-extended fieldk, computed in `LANE_W+1` bits, so it never overflows.
- States:
  - **IDLE → SWEEP** on an accepted `start`. The sweep index is set to 1.
  - **SWEEP**: emits field0 + field[idx] each cycle, then increments idx. When idx = `LANES-1`, it asserts `last` and returns to IDLE.
- Command priority in IDLE, one per cycle: `load` > `start` > `req`. Lower-priority commands asserted in the same cycle are dropped.
- `load` writes `d_reg` <= `d`. It produces no output.
- `req` handling:
  - When `sel` is between 1 and `LANES-1`: `out` = field0 + field[sel], `validout` = 1, `last` = 0.
  - When `sel` = 0 or `sel` ≥ `LANES` (null request): `out` = 0, `validout` = 0.
- While `busy` = 1, `load`, `req` and `start` are all ignored. `d_reg` stays frozen for the whole sweep.
- In any cycle with no output: `validout` = 0, `last` = 0, and `out` = 0.
- Reset asserted mid-sweep aborts the sweep immediately. All outputs return to their reset values; no `last` is emitted.

## Timing
- `load` at edge n: the new `d_reg` is visible to a `req` or `start` sampled at edge n+1.
- `req` at edge n: the result appears on `out`/`validout` after edge n, for exactly 1 cycle. Latency is 1 cycle.
- `start` at edge n:
  - `busy` = 1 from edge n through the edge that presents the last result.
  - Results for k = 1 … `LANES-1` appear in consecutive cycles after edges n … n+`LANES-2`.
  - `last` = 1 on the final result only.
  - `busy` = 0 after edge n+`LANES-1`. The earliest next `start` accepted is at edge n+`LANES-1`.
- `LANES` = 2: a sweep is a single result with `validout`, `last` and `busy` all high for one cycle.
- Throughput: one result per cycle, for both `req` streams and sweeps.

## Configuration
- `DATA_CAL_SAT_EN` defined:
  - The sum saturates at 2^`LANE_W`-1.
  - `out[LANE_W]` is always 0.
  - Any sum that clamps also sets the sticky status bit `sat_seen`, visible as an extra output port `sat_seen` (1 bit, reset 0). Only `load` clears it.
- `DATA_CAL_SAT_EN` undefined:
  - Full `LANE_W+1`-bit sum, as above.
  - The `sat_seen` port does not exist.

## Test plan
All scenarios use `LANES`=4, `LANE_W`=4.
- Reset with `d`=16'hF731 applied, then release → all outputs 0; a `req` with `sel`=1 gives `out`=0 because `d_reg` = 0.
- `load` with `d`=16'hF731, then `req` with `sel`=1, 2, 3 on consecutive cycles → `out` = 5'd4, 5'd8, 5'd16, `validout` high for 3 cycles, `last` = 0.
- `req` with `sel`=0 → `validout` = 0, `out` = 0. Asserting `load` and `start` together with `d`=16'h1111 → only the load happens; `busy` stays 0.
- `start` after loading 16'hF731 → outputs 4, 8, 16 in 3 consecutive cycles with `last` on 16, `busy` high for 3 cycles; a `load` of 16'h0000 mid-sweep is ignored.
- Reset pulsed in the second sweep cycle → outputs go to 0 immediately, no `last`; after release, state is IDLE and a `req` is accepted.
- With `DATA_CAL_SAT_EN`: `sel`=3 on 16'hF731 → `out` = 5'd15 and `sat_seen` = 1; a following `load` clears `sat_seen`.

Source files
------------

// File: rtl/data_cal_seq.sv
// data_cal_seq: lane-sum unit, adds field 0 of a captured word to a chosen
// field, either on single requests or as a sweep over fields 1..LANES-1.
// Ports: clk, rst (async, active-low), d (LANES*LANE_W data word),
//   load (capture d), req + sel (single sum), start (launch sweep),
//   out (LANE_W+1 registered sum), validout, last (final sweep result),
//   busy (sweep in progress, commands ignored).
// Option DATA_CAL_SAT_EN: sums clamp at 2^LANE_W-1 and a sticky
//   sat_seen output (cleared only by load) flags any clamp.
module data_cal_seq #(
  parameter int LANES  = 4,
  parameter int LANE_W = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [LANES*LANE_W-1:0] d,
  input  logic                    load,
  input  logic                    req,
  input  logic [$clog2(LANES)-1:0] sel,
  input  logic                    start,
  output logic [LANE_W:0]         out,
  output logic                    validout,
  output logic                    last,
  output logic                    busy
`ifdef DATA_CAL_SAT_EN
  ,
  output logic                    sat_seen
`endif
);

  localparam int SEL_W = $clog2(LANES);
  localparam int NSEL  = 1 << SEL_W;
  // Bit k set when sel=k names a real field other than field 0.
  localparam logic [NSEL-1:0] SEL_MASK = NSEL'((1 << LANES) - 2);
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(LANES - 1);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t                   state;
  logic [SEL_W-1:0]         idx;
  logic [LANES*LANE_W-1:0]  d_reg;

  logic [LANE_W-1:0] lane [LANES];
  logic [SEL_W-1:0]  pick;
  logic [LANE_W:0]   sum_raw;
  logic [LANE_W:0]   sum_out;
  logic              sel_ok;
  logic              sat_hit;

  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      lane[k] = d_reg[k*LANE_W +: LANE_W];
    end
  end

  // One adder serves both paths: sweep index, first sweep field, or sel.
  always_comb begin
    pick = sel;
    if (state == SWEEP) begin
      pick = idx;
    end else if (start) begin
      pick = SEL_W'(1);
    end
  end

  assign sel_ok  = SEL_MASK[sel];
  assign sum_raw = {1'b0, lane[0]} + {1'b0, lane[pick]};

`ifdef DATA_CAL_SAT_EN
  assign sat_hit = sum_raw[LANE_W];
  assign sum_out = sat_hit ? {1'b0, {LANE_W{1'b1}}} : sum_raw;
`else
  assign sat_hit = 1'b0;
  assign sum_out = sum_raw;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      idx      <= SEL_W'(1);
      d_reg    <= '0;
      out      <= '0;
      validout <= 1'b0;
      last     <= 1'b0;
      busy     <= 1'b0;
`ifdef DATA_CAL_SAT_EN
      sat_seen <= 1'b0;
`endif
    end else begin
      out      <= '0;
      validout <= 1'b0;
      last     <= 1'b0;
      busy     <= 1'b0;
      unique case (state)
        IDLE: begin
          if (load) begin
            d_reg <= d;
`ifdef DATA_CAL_SAT_EN
            sat_seen <= 1'b0;
`endif
          end else if (start) begin
            // First sweep result leaves on the accepting edge.
            out      <= sum_out;
            validout <= 1'b1;
            busy     <= 1'b1;
`ifdef DATA_CAL_SAT_EN
            if (sat_hit) sat_seen <= 1'b1;
`endif
            if (LANES == 2) begin
              last <= 1'b1;
            end else begin
              state <= SWEEP;
              idx   <= SEL_W'(2);
            end
          end else if (req && sel_ok) begin
            out      <= sum_out;
            validout <= 1'b1;
`ifdef DATA_CAL_SAT_EN
            if (sat_hit) sat_seen <= 1'b1;
`endif
          end
        end
        SWEEP: begin
          out      <= sum_out;
          validout <= 1'b1;
          busy     <= 1'b1;
`ifdef DATA_CAL_SAT_EN
          if (sat_hit) sat_seen <= 1'b1;
`endif
          if (idx == LAST_IDX) begin
            last  <= 1'b1;
            state <= IDLE;
            idx   <= SEL_W'(1);
          end else begin
            idx <= idx + SEL_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Keeps sat_hit referenced when saturation is compiled out.
  logic unused_ok;
  assign unused_ok = sat_hit;

endmodule

// File: tb/tb_data_cal_seq.sv
// tb_data_cal_seq: directed table, hand sequences and a random run
// against a queue-based reference model for data_cal_seq (4x4 lanes).
module tb_data_cal_seq;

  localparam int LANES  = 4;
  localparam int LANE_W = 4;
  localparam int SEL_W  = 2;
  localparam int DW     = LANES * LANE_W;
  localparam int OW     = LANE_W + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] d = '0;
  logic          load = 1'b0;
  logic          req = 1'b0;
  logic          start = 1'b0;
  logic [SEL_W-1:0] sel = '0;
  logic [OW-1:0] out;
  logic          validout;
  logic          last;
  logic          busy;
`ifdef DATA_CAL_SAT_EN
  logic          sat_seen;
`endif

  data_cal_seq #(.LANES(LANES), .LANE_W(LANE_W)) dut (
    .clk(clk),
    .rst(rst),
    .d(d),
    .load(load),
    .req(req),
    .sel(sel),
    .start(start),
    .out(out),
    .validout(validout),
    .last(last),
    .busy(busy)
`ifdef DATA_CAL_SAT_EN
    ,
    .sat_seen(sat_seen)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] got();
    return {out, validout, last, busy};
  endfunction

  // Reference model: a queue of field indices still owed by a sweep.
  logic [DW-1:0] m_d = '0;
  int            m_q[$];
  bit            m_sat = 0;

  function automatic int field(input int k);
    return int'(m_d[k*LANE_W +: LANE_W]);
  endfunction

  task automatic msum(input int k, output logic [OW-1:0] s);
    int v;
    v = field(0) + field(k);
`ifdef DATA_CAL_SAT_EN
    if (v > (1 << LANE_W) - 1) begin
      v = (1 << LANE_W) - 1;
      m_sat = 1;
    end
`endif
    s = OW'(v);
  endtask

  task automatic model(input bit ld, input bit rq, input bit st,
                       input int sl, input logic [DW-1:0] dd,
                       output logic [7:0] e);
    logic [OW-1:0] s;
    e = '0;
    if (m_q.size() == 0) begin
      if (ld) begin
        m_d = dd;
        m_sat = 0;
      end else if (st) begin
        for (int k = 1; k < LANES; k++) m_q.push_back(k);
      end else if (rq && sl >= 1 && sl < LANES) begin
        msum(sl, s);
        e = {s, 3'b100};
      end
    end
    if (m_q.size() > 0) begin
      msum(m_q.pop_front(), s);
      e = {s, 1'b1, m_q.size() == 0, 1'b1};
    end
  endtask

  task automatic apply(input bit ld, input bit rq, input bit st,
                       input int sl, input logic [DW-1:0] dd);
    load  = ld;
    req   = rq;
    start = st;
    sel   = SEL_W'(sl);
    d     = dd;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit            ld;
    bit            rq;
    bit            st;
    int            sl;
    logic [DW-1:0] dd;
    int            eo;
    bit            ev;
    bit            el;
    bit            eb;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(bit ld, bit rq, bit st, int sl,
                              logic [DW-1:0] dd, int eo,
                              bit ev, bit el, bit eb);
    vec_t v;
    v.ld = ld; v.rq = rq; v.st = st; v.sl = sl; v.dd = dd;
    v.eo = eo; v.ev = ev; v.el = el; v.eb = eb;
    return v;
  endfunction

  initial begin
    logic [7:0]    e;
    int            eo;
    string         nm;

    tv.push_back(mk(0, 1, 0, 1, 16'hF731,  0, 1, 0, 0));
    tv.push_back(mk(1, 0, 0, 0, 16'hF731,  0, 0, 0, 0));
    tv.push_back(mk(0, 1, 0, 1, 16'h0000,  4, 1, 0, 0));
    tv.push_back(mk(0, 1, 0, 2, 16'h0000,  8, 1, 0, 0));
    tv.push_back(mk(0, 1, 0, 3, 16'h0000, 16, 1, 0, 0));
    tv.push_back(mk(0, 1, 0, 0, 16'h0000,  0, 0, 0, 0));
    tv.push_back(mk(1, 0, 1, 0, 16'h1111,  0, 0, 0, 0));
    tv.push_back(mk(0, 1, 0, 3, 16'h0000,  2, 1, 0, 0));
    tv.push_back(mk(1, 0, 0, 0, 16'hF731,  0, 0, 0, 0));
    tv.push_back(mk(0, 0, 1, 0, 16'h0000,  4, 1, 0, 1));
    tv.push_back(mk(1, 1, 0, 1, 16'h0000,  8, 1, 0, 1));
    tv.push_back(mk(0, 1, 1, 1, 16'h0000, 16, 1, 1, 1));
    tv.push_back(mk(0, 0, 0, 0, 16'h0000,  0, 0, 0, 0));
    tv.push_back(mk(0, 1, 0, 2, 16'h0000,  8, 1, 0, 0));
    tv.push_back(mk(0, 0, 1, 0, 16'h0000,  4, 1, 0, 1));
    tv.push_back(mk(0, 0, 0, 0, 16'h0000,  8, 1, 0, 1));
    tv.push_back(mk(0, 0, 1, 0, 16'h0000, 16, 1, 1, 1));
    tv.push_back(mk(0, 0, 1, 0, 16'h0000,  4, 1, 0, 1));
    tv.push_back(mk(0, 0, 0, 0, 16'h0000,  8, 1, 0, 1));
    tv.push_back(mk(0, 0, 0, 0, 16'h0000, 16, 1, 1, 1));
    tv.push_back(mk(0, 0, 0, 0, 16'h0000,  0, 0, 0, 0));

    // Reset with data applied: everything must read zero.
    d = 16'hF731;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {24'd0, got()}, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("post_reset_idle", {24'd0, got()}, 32'd0);

    foreach (tv[i]) begin
      apply(tv[i].ld, tv[i].rq, tv[i].st, tv[i].sl, tv[i].dd);
      eo = tv[i].eo;
`ifdef DATA_CAL_SAT_EN
      if (eo > 15) eo = 15;
`endif
      nm = $sformatf("vec%0d", i);
      chk(nm, {24'd0, got()},
          {24'd0, OW'(eo), tv[i].ev, tv[i].el, tv[i].eb});
    end

    // Reset in the second sweep cycle aborts with no last.
    apply(1, 0, 0, 0, 16'hF731);
    apply(0, 0, 1, 0, 16'h0000);
    chk("abort_first", {24'd0, got()}, {24'd0, 5'd4, 3'b101});
    apply(0, 0, 0, 0, 16'h0000);
    chk("abort_second", {24'd0, got()}, {24'd0, 5'd8, 3'b101});
    #2;
    rst = 1'b0;
    #1;
    chk("abort_async", {24'd0, got()}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_no_last", {24'd0, got()}, 32'd0);
    apply(0, 1, 0, 1, 16'h0000);
    chk("abort_req", {24'd0, got()}, {24'd0, 5'd0, 3'b100});
    apply(1, 0, 0, 0, 16'hF731);
    apply(0, 1, 0, 3, 16'h0000);
`ifdef DATA_CAL_SAT_EN
    chk("sat_out", {24'd0, got()}, {24'd0, 5'd15, 3'b100});
    chk("sat_flag", {31'd0, sat_seen}, 32'd1);
    apply(1, 0, 0, 0, 16'hF731);
    chk("sat_clear", {31'd0, sat_seen}, 32'd0);
`else
    chk("after_reload", {24'd0, got()}, {24'd0, 5'd16, 3'b100});
`endif

    // Random run against the model, starting from a clean reset.
    load = 0; req = 0; start = 0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    m_d = '0;
    m_q.delete();
    m_sat = 0;
    for (int c = 0; c < 400; c++) begin
      bit            ld, rq, st;
      int            sl;
      logic [DW-1:0] dd;
      ld = ($urandom % 6) == 0;
      st = ($urandom % 5) == 0;
      rq = ($urandom % 2) == 0;
      sl = int'($urandom % LANES);
      dd = DW'($urandom);
      model(ld, rq, st, sl, dd, e);
      apply(ld, rq, st, sl, dd);
      nm = $sformatf("rand%0d", c);
      chk(nm, {24'd0, got()}, {24'd0, e});
`ifdef DATA_CAL_SAT_EN
      chk({nm, "_sat"}, {31'd0, sat_seen}, {31'd0, m_sat});
`endif
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
